// File: rtl/xcvr245_pkg.sv
// Shared types and constants for the 74HCT245 transceiver controller.
package xcvr245_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SETTLE,
    S_OWN,
    S_DRAIN
  } xcvr_state_t;

  typedef enum logic {
    OWN_AB,
    OWN_BA
  } owner_t;

  localparam logic DIR_AB = 1'b1;
  localparam logic DIR_BA = 1'b0;

  // Round-robin pick: on a tie the side that did not own last wins.
  function automatic owner_t arb_pick(input logic ab, input logic ba, input owner_t last);
    if (ab && ba) return (last == OWN_AB) ? OWN_BA : OWN_AB;
    else if (ab)  return OWN_AB;
    else          return OWN_BA;
  endfunction

endpackage

// File: rtl/xcvr245_dwell_timer.sv
// Loadable saturating down-counter; done is high once the count reaches zero.
module dwell_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;

  // Load on request, otherwise count down and hold at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/xcvr245_ctrl.sv
// Sequences dir/nOE of one shared octal transceiver between an A->B and a
// B->A requester, with dead time around every direction change and an
// enable-settling wait before each grant.
module xcvr245_ctrl
  import xcvr245_pkg::*;
#(
  parameter int TURN_CYCLES   = 2,
  parameter int SETTLE_CYCLES = 2,
  parameter int MAX_HOLD      = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic req_ab,
  input  logic req_ba,
  output logic dir,
  output logic nOE,
  output logic gnt_ab,
  output logic gnt_ba,
  output logic busy
);

  localparam int TMAX = (TURN_CYCLES > SETTLE_CYCLES) ? TURN_CYCLES : SETTLE_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int HW   = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  // A dwell of N cycles is loaded as N-1 so done fires on the Nth edge.
  localparam logic [TW-1:0] TURN_LD   = TW'(TURN_CYCLES - 1);
  localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  xcvr_state_t   state_q, state_d;
  owner_t        cur_q, cur_d, last_q, last_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          dir_q, dir_d, noe_q, noe_d;
  logic          gab_q, gab_d, gba_q, gba_d, busy_q, busy_d;
  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_done;
  owner_t        win;
  logic          cur_req, oth_req;

  dwell_timer #(.W(TW)) u_dwell (
    .clk    (clk),
    .rst    (rst),
    .load_i (tmr_load),
    .val_i  (tmr_val),
    .done_o (tmr_done)
  );

  assign win     = arb_pick(req_ab, req_ba, last_q);
  assign cur_req = (cur_q == OWN_AB) ? req_ab : req_ba;
  assign oth_req = (cur_q == OWN_AB) ? req_ba : req_ab;

  // Next-state and next-output decode; outputs follow the next state so they are registered.
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    last_d   = last_q;
    hold_d   = hold_q;
    dir_d    = dir_q;
    tmr_load = 1'b0;
    tmr_val  = TURN_LD;
    unique case (state_q)
      S_IDLE, S_DRAIN: begin
        // DRAIN hands straight to a pending request so there is no idle bubble.
        if (state_q == S_IDLE || tmr_done) begin
          if (req_ab || req_ba) begin
            state_d  = S_SETUP;
            cur_d    = win;
            dir_d    = (win == OWN_AB) ? DIR_AB : DIR_BA;
            tmr_load = 1'b1;
            tmr_val  = TURN_LD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_SETUP, S_SETTLE: begin
        if (!cur_req) begin
          state_d  = S_DRAIN;
          tmr_load = 1'b1;
          tmr_val  = TURN_LD;
        end else if (tmr_done && state_q == S_SETUP) begin
          state_d  = S_SETTLE;
          tmr_load = 1'b1;
          tmr_val  = SETTLE_LD;
        end else if (tmr_done) begin
          state_d = S_OWN;
          last_d  = cur_q;
          hold_d  = '0;
        end
      end
      S_OWN: begin
        if (!cur_req) begin
          state_d  = S_DRAIN;
          tmr_load = 1'b1;
        end else if (MAX_HOLD > 0 && oth_req) begin
          hold_d = hold_q + HW'(1);
          if (hold_q == HOLD_LAST) begin
            state_d  = S_DRAIN;
            tmr_load = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    noe_d  = !(state_d == S_SETTLE || state_d == S_OWN);
    gab_d  = (state_d == S_OWN) && (cur_d == OWN_AB);
    gba_d  = (state_d == S_OWN) && (cur_d == OWN_BA);
    busy_d = (state_d != S_IDLE);
  end

  // State and registered pin drivers; reset parks the transceiver disabled, A->B.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cur_q   <= OWN_BA;
      last_q  <= OWN_BA;
      hold_q  <= '0;
      dir_q   <= DIR_AB;
      noe_q   <= 1'b1;
      gab_q   <= 1'b0;
      gba_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      dir_q   <= dir_d;
      noe_q   <= noe_d;
      gab_q   <= gab_d;
      gba_q   <= gba_d;
      busy_q  <= busy_d;
    end
  end

  assign dir    = dir_q;
  assign nOE    = noe_q;
  assign gnt_ab = gab_q;
  assign gnt_ba = gba_q;
  assign busy   = busy_q;

endmodule
